spongent_squeezing_phase: RTL and testbench
===========================================

// Module: spongent_squeezing_phase
// PURPOSE
//  Squeezing (output) phase of the SPONGENT sponge. It takes the b-bit state left by
//  the absorbing phase and emits the N-bit digest, r bits at a time.
//  It drives the shared permutation instance through the same rst/initial_state/end
//  handshake that the absorbing side uses. Sits between absorbing end and spongent.hash/end_hash.
// PARAMETERS
//  N   88  digest width; must be an integer multiple of r
//  b   88  sponge state width (c+r)
//  r   8   rate width; chunk taken from state[r-1:0]
//  NCH N/r (localparam) number of chunks squeezed
// PORTS
//  clk                        in  1  clock, rising edge
//  rst                        in  1  reset, asynchronous, active-low
//  start                      in  1  level; sampled in IDLE/DONE only (tie to end_absorbing)
//  absorbed_state             in  b  state to squeeze, latched when start accepted
//  end_permutation            in  1  permutation finished, permutation_state valid
//  permutation_state          in  b  permutation result
//  rst_permutation            out 1  high = permutation held/loaded from permutation_initial_state
//  permutation_initial_state  out b  = internal state register
//  hash                       out N  digest, first chunk in hash[N-1 -: r]
//  end_hash                   out 1  high while hash is complete and valid
//  busy                       out 1  high in EXTRACT/PERMUTATION
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; state_q=0; hash=0; chunk cnt=0; end_hash=0; busy=0; rst_permutation=1.
//  FSM IDLE, EXTRACT, PERMUTATION, DONE (rst_permutation=0 only in PERMUTATION):
//   IDLE: if start: state_q<=absorbed_state, hash<=0, cnt<=0 -> EXTRACT.
//   EXTRACT (1 cycle): hash<={hash[N-r-1:0],state_q[r-1:0]}; cnt<=cnt+1.
//     if cnt==NCH-1 -> DONE, else -> PERMUTATION (perm loads state_q on this edge).
//   PERMUTATION: wait end_permutation; on it state_q<=permutation_state -> EXTRACT.
//     No permutation after the last chunk (NCH extractions, NCH-1 permutations).
//   DONE: end_hash=1; hash held; start=1 -> relatch absorbed_state, clear hash/cnt -> EXTRACT
//     (end_hash drops the next cycle).
//  Latency: permutation of R rounds occupies R+1 cycles; end_hash rises NCH+(NCH-1)*(R+1)
//   cycles after start-accepting edge (N=88,r=8,R=45: 471).
//  start in EXTRACT/PERMUTATION ignored; absorbed_state changes after accept ignored.
//  end_permutation outside PERMUTATION ignored. cnt width $clog2(NCH+1), never wraps.
//  Async reset mid-operation: immediate return to reset values; no partial hash visible.
// CONFIGURATION
//  SPONGENT_SQUEEZE_STREAM_EN defined: extra outputs chunk_valid(1), chunk_out(r);
//   chunk_valid pulses 1 cycle in every EXTRACT with chunk_out=state_q[r-1:0]
//   (exactly NCH pulses per digest), both reset to 0.
//  Not defined: ports absent; only the parallel hash/end_hash output.
// STRUCTURE
//  spongent_pkg: squeeze_state_t enum {IDLE,EXTRACT,PERMUTATION,DONE}; function
//   num_chunks(N,r); shared with absorbing_phase.
//  Sub-module: existing counter instance for cnt (up=EXTRACT, din=0, rst=start accept).
//  Permutation is external; the top-level spongent muxes rst_permutation/initial_state
//   between absorbing and squeezing phases on end_absorbing.
// TESTING
//  Bench stub permutation: result=initial_state+1, end_permutation after R=45 rounds.
//  1 Reset: assert rst=0 mid-sim -> hash=0,end_hash=0,busy=0,rst_permutation=1 same cycle.
//  2 absorbed_state=88'h0A, start -> hash=88'h0A0B0C0D0E0F1011121314, end_hash at cycle 471.
//  3 start toggled during PERMUTATION -> no restart, same digest and 471-cycle latency.
//  4 From DONE, start with absorbed_state=88'hF0 -> end_hash drops 1 cycle, hash=F0F1..FA.
//  5 rst=0 in 5th PERMUTATION, release, start 88'h0A -> digest as in 2, no stale chunks.
//  6 STREAM_EN: case 2 -> 11 chunk_valid pulses, chunk_out 0A..14 in order, 47 cycles apart.

Source files
------------

// File: rtl/spongent_squeezing_phase_pkg.sv
// Shared SPONGENT definitions: squeeze FSM state encoding and chunk-count helper.
package spongent_squeezing_phase_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EXTRACT     = 2'd1,
        PERMUTATION = 2'd2,
        DONE        = 2'd3
    } squeeze_state_t;

    function automatic int num_chunks(input int n, input int r_w);
        return n / r_w;
    endfunction

endpackage

// File: rtl/spongent_squeezing_phase_if.sv
// Squeeze-phase bus: start/state input, permutation handshake and digest output.
// Optional streaming outputs appear when SPONGENT_SQUEEZE_STREAM_EN is defined.
interface spongent_squeezing_phase_if #(
    parameter int N = 88,
    parameter int b = 88,
    parameter int r = 8
);
    logic         start;
    logic [b-1:0] absorbed_state;
    logic         end_permutation;
    logic [b-1:0] permutation_state;
    logic         rst_permutation;
    logic [b-1:0] permutation_initial_state;
    logic [N-1:0] hash;
    logic         end_hash;
    logic         busy;
`ifdef SPONGENT_SQUEEZE_STREAM_EN
    logic         chunk_valid;
    logic [r-1:0] chunk_out;

    modport master (
        output start, absorbed_state, end_permutation, permutation_state,
        input  rst_permutation, permutation_initial_state, hash, end_hash, busy,
        input  chunk_valid, chunk_out
    );
    modport slave (
        input  start, absorbed_state, end_permutation, permutation_state,
        output rst_permutation, permutation_initial_state, hash, end_hash, busy,
        output chunk_valid, chunk_out
    );
`else
    modport master (
        output start, absorbed_state, end_permutation, permutation_state,
        input  rst_permutation, permutation_initial_state, hash, end_hash, busy
    );
    modport slave (
        input  start, absorbed_state, end_permutation, permutation_state,
        output rst_permutation, permutation_initial_state, hash, end_hash, busy
    );
`endif
endinterface

// File: rtl/spongent_squeezing_phase_counter.sv
// Up counter with synchronous load; counts squeezed chunks.
module spongent_squeezing_phase_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_count <= '0;
        else if (i_load) r_count <= i_din;
        else if (i_up)   r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/spongent_squeezing_phase.sv
// SPONGENT squeezing phase: emits the N-bit digest r bits at a time, driving the
// shared permutation between chunks. Streaming outputs under SPONGENT_SQUEEZE_STREAM_EN.
module spongent_squeezing_phase
    import spongent_squeezing_phase_pkg::*;
#(
    parameter int N = 88,
    parameter int b = 88,
    parameter int r = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    spongent_squeezing_phase_if.slave bus
);
    localparam int NCH = num_chunks(N, r);
    localparam int CW  = $clog2(NCH + 1);

    squeeze_state_t r_state, w_next;
    logic [b-1:0]   r_state_q;
    logic [N-1:0]   r_hash;
    logic [CW-1:0]  w_cnt;
    logic           w_accept;
    logic           w_extract;
    logic           w_last;

    assign w_extract = (r_state == EXTRACT);
    assign w_last    = (w_cnt == CW'(NCH - 1));

    spongent_squeezing_phase_counter #(.WIDTH(CW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_up    (w_extract),
        .i_din   ('0),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // NOTE: defaults assigned first so no path through the case can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = EXTRACT;
                end
            end
            EXTRACT:     w_next = w_last ? DONE : PERMUTATION;
            PERMUTATION: if (bus.end_permutation) w_next = EXTRACT;
            default:     w_next = IDLE;
        endcase
    end

    // Chunks shift in from the right so the first one ends up in the MSBs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= '0;
            r_hash    <= '0;
        end else if (w_accept) begin
            r_state_q <= bus.absorbed_state;
            r_hash    <= '0;
        end else if (w_extract) begin
            r_hash    <= {r_hash[N-r-1:0], r_state_q[r-1:0]};
        end else if (r_state == PERMUTATION && bus.end_permutation) begin
            r_state_q <= bus.permutation_state;
        end
    end

    assign bus.rst_permutation           = (r_state != PERMUTATION);
    assign bus.permutation_initial_state = r_state_q;
    assign bus.hash                      = r_hash;
    assign bus.end_hash                  = (r_state == DONE);
    assign bus.busy                      = (r_state == EXTRACT) || (r_state == PERMUTATION);

`ifdef SPONGENT_SQUEEZE_STREAM_EN
    assign bus.chunk_valid = w_extract;
    assign bus.chunk_out   = w_extract ? r_state_q[r-1:0] : '0;
`endif
endmodule

// File: tb/tb_spongent_squeezing_phase.sv
// Directed bench for spongent_squeezing_phase with a stub permutation (state+1 after 45 rounds).
module tb_spongent_squeezing_phase;
    localparam int N      = 88;
    localparam int B      = 88;
    localparam int R      = 8;
    localparam int NCH    = N / R;
    localparam int ROUNDS = 45;
    localparam int LAT    = 471;
    localparam logic [N-1:0] DIGEST_0A = 88'h0A0B0C0D0E0F1011121314;
    localparam logic [N-1:0] DIGEST_F0 = 88'hF0F1F2F3F4F5F6F7F8F9FA;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    spongent_squeezing_phase_if #(.N(N), .b(B), .r(R)) sif ();

    spongent_squeezing_phase #(.N(N), .b(B), .r(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    // Stub permutation: loads while held, finishes ROUNDS cycles after release.
    logic [B-1:0] perm_q;
    int           perm_rounds;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            perm_q      <= '0;
            perm_rounds <= 0;
        end else if (sif.rst_permutation) begin
            perm_q      <= sif.permutation_initial_state;
            perm_rounds <= 0;
        end else if (perm_rounds < ROUNDS) begin
            perm_rounds <= perm_rounds + 1;
        end
    end

    assign sif.permutation_state = perm_q + 1'b1;
    assign sif.end_permutation   = !sif.rst_permutation && (perm_rounds == ROUNDS);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hash"},     sif.hash, '0);
        check({tag, "_end_hash"}, sif.end_hash, 1'b0);
        check({tag, "_busy"},     sif.busy, 1'b0);
        check({tag, "_rst_perm"}, sif.rst_permutation, 1'b1);
    endtask

    // Called at #1 after a posedge; start is sampled on the next edge.
    task automatic run_squeeze(input string tag, input logic [B-1:0] abs_state,
                               input logic [N-1:0] exp_hash, input bit toggle_start);
        int cycles;
        bit seen;
`ifdef SPONGENT_SQUEEZE_STREAM_EN
        int pulses;
        int last;
        bit spacing_ok;
        pulses     = 0;
        last       = -1;
        spacing_ok = 1'b1;
`endif
        cycles = 0;
        seen   = 1'b0;
        sif.absorbed_state = abs_state;
        sif.start          = 1'b1;
        @(posedge clk); #1;
        sif.start          = 1'b0;
        sif.absorbed_state = {$urandom, $urandom, $urandom};
        check({tag, "_accept_hash_cleared"}, sif.hash, '0);
        check({tag, "_accept_end_hash"},     sif.end_hash, 1'b0);
        check({tag, "_accept_busy"},         sif.busy, 1'b1);
        while (1) begin
`ifdef SPONGENT_SQUEEZE_STREAM_EN
            if (sif.chunk_valid) begin
                if (pulses < NCH)
                    check({tag, "_chunk_out"}, sif.chunk_out, exp_hash[N-1-R*pulses -: R]);
                if (last >= 0 && (cycles - last) != 47) spacing_ok = 1'b0;
                last = cycles;
                pulses++;
            end
`endif
            seen = sif.end_hash;
            if (seen || cycles >= 1000) break;
            @(posedge clk); #1;
            cycles++;
            if (toggle_start) sif.start = (cycles >= 100 && cycles < 110) ? cycles[0] : 1'b0;
        end
        check({tag, "_latency"},   cycles, LAT);
        check({tag, "_hash"},      sif.hash, exp_hash);
        check({tag, "_done_busy"}, sif.busy, 1'b0);
        check({tag, "_done_rst_perm"}, sif.rst_permutation, 1'b1);
`ifdef SPONGENT_SQUEEZE_STREAM_EN
        check({tag, "_chunk_pulses"}, pulses, NCH);
        check({tag, "_chunk_spacing"}, spacing_ok, 1'b1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.start          = 1'b0;
        sif.absorbed_state = '0;

        #12;
        check_reset_values("por");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", sif.busy, 1'b0);
        check("idle_end_hash", sif.end_hash, 1'b0);

        // Basic digest from IDLE, absorbed_state scrambled after accept.
        run_squeeze("t2", 88'h0A, DIGEST_0A, 1'b0);

        // Restart from DONE with start toggling mid-permutation.
        @(posedge clk); #1;
        check("t3_done_hold", sif.hash, DIGEST_0A);
        run_squeeze("t3", 88'h0A, DIGEST_0A, 1'b1);

        // Restart from DONE with a new state.
        run_squeeze("t4", 88'hF0, DIGEST_F0, 1'b0);

        // Async reset during the 5th permutation.
        sif.absorbed_state = 88'hF0;
        sif.start          = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("t5_in_perm_rst_perm", sif.rst_permutation, 1'b0);
        check("t5_in_perm_busy", sif.busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_reset_values("t5_async");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("t5_released");
        run_squeeze("t5", 88'h0A, DIGEST_0A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
